// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode classes, register addressing and immediate extension.
// Pure combinational helpers; no state.
package decode_stage_pkg;

  localparam int                REG_AW        = 4;
  localparam logic [31:0]       NOP_INSTR_DEF = 32'hE1A00000;
  localparam logic [REG_AW-1:0] PC_REG        = 4'd15;

  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Branch offsets are word counts, hence the shift before use as a byte offset.
  function automatic logic [31:0] ext_imm(input logic [31:0] instr);
    logic [31:0] imm;
    case (op_e'(instr[27:26]))
      OP_DP:   imm = {24'd0, instr[7:0]};
      OP_MEM:  imm = {20'd0, instr[11:0]};
      OP_BR:   imm = {{6{instr[23]}}, instr[23:0], 2'b00};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file_15.sv
// 15-entry register file with combinational reads, same-cycle write bypass and R15 = PC+8.
// Reads are zero latency; writes land at the rising edge; no backpressure.
module reg_file_15
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we3,
  input  logic [REG_AW-1:0] i_wa3,
  input  logic [31:0]       i_wd3,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  input  logic [31:0]       i_r15,
  output logic [31:0]       o_rd1,
  output logic [31:0]       o_rd2
);

  logic [31:0] r_regs [15];
  logic        w_wr_en;

  // R15 has no storage, so writes addressed to it are dropped here.
  assign w_wr_en = i_we3 && (i_wa3 != PC_REG);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_wa3] <= i_wd3;
    end
  end

  always_comb begin
    if (i_ra1 == PC_REG)                    o_rd1 = i_r15;
    else if (w_wr_en && (i_wa3 == i_ra1))   o_rd1 = i_wd3;
    else                                    o_rd1 = r_regs[i_ra1];
  end

  always_comb begin
    if (i_ra2 == PC_REG)                    o_rd2 = i_r15;
    else if (w_wr_en && (i_wa3 == i_ra2))   o_rd2 = i_wd3;
    else                                    o_rd2 = r_regs[i_ra2];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, register-file read and immediate extension.
// One cycle from Instr to decoded outputs; StallD holds the IF/ID register, FlushD inserts a bubble.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       Instr,
  input  logic [31:0]       PCPlus4,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              WE3,
  input  logic [REG_AW-1:0] WA3,
  input  logic [31:0]       WD3,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus8D,
  output logic [31:0]       RD1,
  output logic [31:0]       RD2,
  output logic [31:0]       ExtImm,
  output logic [3:0]        CondD,
  output logic              ValidD
);

  logic [31:0]       r_instr;
  logic [31:0]       r_pc4;
  logic              r_valid;
  logic [31:0]       w_pc8;
  op_e               w_op;
  logic [REG_AW-1:0] w_ra1;
  logic [REG_AW-1:0] w_ra2;

  always_ff @(posedge clk) begin
    if (!rst_n || FlushD) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!StallD) begin
      r_instr <= Instr;
      r_pc4   <= PCPlus4;
      r_valid <= 1'b1;
    end
  end

  assign w_pc8 = r_pc4 + 32'd4;
  assign w_op  = op_e'(r_instr[27:26]);

  // Branches read the PC as base; stores read the data register from the Rd field.
  assign w_ra1 = (w_op == OP_BR)  ? PC_REG          : r_instr[19:16];
  assign w_ra2 = (w_op == OP_MEM) ? r_instr[15:12]  : r_instr[3:0];

  reg_file_15 u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_we3 (WE3),
    .i_wa3 (WA3),
    .i_wd3 (WD3),
    .i_ra1 (w_ra1),
    .i_ra2 (w_ra2),
    .i_r15 (w_pc8),
    .o_rd1 (RD1),
    .o_rd2 (RD2)
  );

  assign InstrD   = r_instr;
  assign PCPlus8D = w_pc8;
  assign ExtImm   = ext_imm(r_instr);
  assign CondD    = r_instr[31:28];
  assign ValidD   = r_valid;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'hE1A00000, meaning the instruction word loaded into the IF/ID register on reset or flush.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port Instr, input, 32 bits: the instruction from the fetch stage.
REQ-005 The block SHALL have port PCPlus4, input, 32 bits: the fetch-stage PC+4.
REQ-006 The block SHALL have port StallD, input, 1 bit: hold the IF/ID register.
REQ-007 The block SHALL have port FlushD, input, 1 bit: replace the IF/ID contents with a bubble.
REQ-008 The block SHALL have write-back ports WE3 (input, 1 bit), WA3 (input, 4 bits) and WD3 (input, 32 bits).
REQ-009 The block SHALL have outputs InstrD (32 bits), PCPlus8D (32 bits), RD1 (32 bits), RD2 (32 bits), ExtImm (32 bits), CondD (4 bits) and ValidD (1 bit).

Function
REQ-010 The IF/ID register SHALL apply this priority each edge: reset, then FlushD, then StallD, then normal capture.
- Reset or FlushD: InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0.
- StallD: hold all values.
- Normal: InstrD=Instr, PCPlus4D=PCPlus4, ValidD=1.
REQ-011 PCPlus8D SHALL equal PCPlus4D+4, modulo 2^32 (wraps from 32'hFFFFFFFC to 0).
REQ-012 op SHALL be InstrD[27:26].
- RA1 = 4'd15 when op=2'b10, else InstrD[19:16].
- RA2 = InstrD[15:12] when op=2'b01, else InstrD[3:0].
REQ-013 The register file SHALL hold r0..r14, each 32 bits.
REQ-014 Register-file reads SHALL be combinational:
- Address 15 returns PCPlus8D.
- Otherwise returns reg[RA].
REQ-015 When WE3=1, WA3==RA and WA3!=15, the read SHALL return WD3 in the same cycle (write-through bypass).
REQ-016 The register file SHALL write reg[WA3]<=WD3 at the rising edge when WE3=1 and WA3!=15.
- Writes with WA3=15 are ignored.
- Writes are independent of StallD, FlushD and ValidD.
REQ-017 ExtImm SHALL be decoded from InstrD by op:
- op=00: zero-extend InstrD[7:0].
- op=01: zero-extend InstrD[11:0].
- op=10: sign-extend InstrD[23:0] shifted left 2.
- op=11: 32'd0.
REQ-018 CondD SHALL equal InstrD[31:28].
REQ-019 Latency SHALL be one cycle from Instr to InstrD, RD1, RD2 and ExtImm.
REQ-020 When ValidD=0, RD1, RD2 and ExtImm SHALL still be computed from NOP_INSTR; downstream qualifies them with ValidD.

Reset
REQ-021 While rst_n=0 at an edge, r0..r14 SHALL be cleared to 0 and the IF/ID register SHALL load the reset values of REQ-010.
REQ-022 Reset SHALL override a simultaneous WE3 write, FlushD or StallD.
REQ-023 Reset asserted mid-stall SHALL drop the held instruction.

Structure
REQ-024 A shared package SHALL hold: op encodings (OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10), NOP_INSTR default, PC_REG=4'd15, and the register-address width.
REQ-025 The register file SHALL be one sub-module, reg_file_15, covering storage, bypass and the R15 substitution.
REQ-026 The IF/ID register and immediate extension SHALL be implemented in decode_stage.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset then Instr=32'hE2811005, PCPlus4=32'h8 for one cycle -> InstrD=32'hE2811005, ValidD=1, ExtImm=5, PCPlus8D=32'hC, CondD=4'hE.
- WE3=1, WA3=3, WD3=32'hDEADBEEF, with InstrD reading Rn=3 in the same cycle -> RD1=32'hDEADBEEF that cycle (bypass), and still next cycle.
- WE3=1, WA3=15, WD3=32'h1234 -> no register changes; a later R15 read returns PCPlus8D.
- Branch InstrD=32'hEAFFFFFE -> RA1=15, ExtImm=32'hFFFFFFF8.
- StallD=1 for 3 cycles while Instr changes -> InstrD held; FlushD=1 together with StallD=1 -> InstrD=NOP_INSTR, ValidD=0.
- rst_n=0 during a stall with WE3=1 to r2 -> r2 reads 0 and ValidD=0 after the reset edge.
